// File: rtl/base_pipeline.sv
// base_pipeline: five-stage in-order RV32I integer pipeline (F, D, EX, STL, WB).
// Supports R-type ALU, OP-IMM ALU, LW and SW. No control flow: the pc only
// increments. Instruction and data memories are external and synchronous.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   imem_addr  fetch address (= pc)
//   imem_en    fetch enable, high whenever out of reset
//   imem_dout  instruction word, registered by the memory one cycle after address
//   dmem_addr  data address (ALU result of the instruction in STL)
//   dmem_we    word store strobe
//   dmem_din   store data
//   dmem_dout  load data, valid one cycle after address
//   pc_out     current pc for debug
//
// Optional feature macro: FORWARDING_EN
//   Defined: EX operands are bypassed from STL (non-load results) and from WB,
//   with STL taking priority. Undefined: only register-file write-through.
module base_pipeline #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    output logic        imem_en,
    input  logic [31:0] imem_dout,
    output logic [31:0] dmem_addr,
    output logic        dmem_we,
    output logic [31:0] dmem_din,
    input  logic [31:0] dmem_dout,
    output logic [31:0] pc_out
);

    typedef enum logic [3:0] {
        AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd
    } alu_op_e;

    localparam logic [6:0] OpReg   = 7'b0110011;
    localparam logic [6:0] OpImm   = 7'b0010011;
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;

    logic [31:0] pc_d, pc_q;

    // D -> EX
    logic        rs1_en_ex_d, rs1_en_ex_q, rs2_en_ex_d, rs2_en_ex_q, rd_en_ex_d, rd_en_ex_q;
    logic        b_is_immediate_ex_d, b_is_immediate_ex_q;
    logic        rd_is_ram_dout_ex_d, rd_is_ram_dout_ex_q, ram_we_ex_d, ram_we_ex_q;
    logic [4:0]  rd_addr_ex_d, rd_addr_ex_q, rs1_addr_ex_d, rs1_addr_ex_q;
    logic [4:0]  rs2_addr_ex_d, rs2_addr_ex_q;
    logic [31:0] rs1_value_ex_d, rs1_value_ex_q, rs2_value_ex_d, rs2_value_ex_q;
    logic [31:0] imm_ex_d, imm_ex_q;
    alu_op_e     alu_op_ex_d, alu_op_ex_q;

    // EX -> STL
    logic        rd_en_stl_d, rd_en_stl_q, rd_is_ram_dout_stl_d, rd_is_ram_dout_stl_q;
    logic        ram_we_stl_d, ram_we_stl_q;
    logic [4:0]  rd_addr_stl_d, rd_addr_stl_q;
    logic [31:0] rd_value_stl_d, rd_value_stl_q, store_data_stl_d, store_data_stl_q;

    // STL -> WB
    logic        rd_en_wb_d, rd_en_wb_q, rd_is_ram_dout_wb_d, rd_is_ram_dout_wb_q;
    logic [4:0]  rd_addr_wb_d, rd_addr_wb_q;
    logic [31:0] rd_value_wb_d, rd_value_wb_q;

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s;
    logic        wb_we;
    logic [31:0] wb_data;
    logic [31:0] rs1_rdata, rs2_rdata;
    logic [31:0] op_a, rs2_op, op_b, alu_y;

    assign instr  = imem_dout;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};

    assign wb_data = rd_is_ram_dout_wb_q ? dmem_dout : rd_value_wb_q;
    assign wb_we   = rd_en_wb_q && (rd_addr_wb_q != 5'd0);

    // Register file: storage is not reset; entry 0 is forced to zero every cycle.
    if (1'b1) begin : register_file0
        logic [31:0] data [0:31];
        always_ff @(posedge clk) begin
            for (int i = 0; i < 32; i++) begin
                if (i == 0) begin
                    data[i] <= '0;
                end else if (wb_we && (rd_addr_wb_q == 5'(i))) begin
                    data[i] <= wb_data;
                end
            end
        end
    end

    // Write-through read so D sees the value WB is committing this cycle.
    always_comb begin
        rs1_rdata = register_file0.data[rs1];
        rs2_rdata = register_file0.data[rs2];
        if (rs1 == 5'd0) rs1_rdata = '0;
        else if (wb_we && (rd_addr_wb_q == rs1)) rs1_rdata = wb_data;
        if (rs2 == 5'd0) rs2_rdata = '0;
        else if (wb_we && (rd_addr_wb_q == rs2)) rs2_rdata = wb_data;
    end

    // Decode
    always_comb begin
        rs1_en_ex_d         = 1'b0;
        rs2_en_ex_d         = 1'b0;
        rd_en_ex_d          = 1'b0;
        b_is_immediate_ex_d = 1'b0;
        rd_is_ram_dout_ex_d = 1'b0;
        ram_we_ex_d         = 1'b0;
        imm_ex_d            = '0;
        alu_op_ex_d         = AluAdd;
        rd_addr_ex_d        = rd;
        rs1_addr_ex_d       = rs1;
        rs2_addr_ex_d       = rs2;
        rs1_value_ex_d      = rs1_rdata;
        rs2_value_ex_d      = rs2_rdata;
        unique case (opcode)
            OpReg, OpImm: begin
                rs1_en_ex_d         = 1'b1;
                rs2_en_ex_d         = (opcode == OpReg);
                b_is_immediate_ex_d = (opcode == OpImm);
                rd_en_ex_d          = (rd != 5'd0);
                imm_ex_d            = (opcode == OpImm) ? imm_i : '0;
                unique case (funct3)
                    3'b000: alu_op_ex_d = (opcode == OpReg && instr[30]) ? AluSub : AluAdd;
                    3'b001: alu_op_ex_d = AluSll;
                    3'b010: alu_op_ex_d = AluSlt;
                    3'b011: alu_op_ex_d = AluSltu;
                    3'b100: alu_op_ex_d = AluXor;
                    3'b101: alu_op_ex_d = instr[30] ? AluSra : AluSrl;
                    3'b110: alu_op_ex_d = AluOr;
                    default: alu_op_ex_d = AluAnd;
                endcase
            end
            OpLoad: begin
                if (funct3 == 3'b010) begin
                    rs1_en_ex_d         = 1'b1;
                    b_is_immediate_ex_d = 1'b1;
                    rd_is_ram_dout_ex_d = 1'b1;
                    rd_en_ex_d          = (rd != 5'd0);
                    imm_ex_d            = imm_i;
                end
            end
            OpStore: begin
                if (funct3 == 3'b010) begin
                    rs1_en_ex_d         = 1'b1;
                    rs2_en_ex_d         = 1'b1;
                    b_is_immediate_ex_d = 1'b1;
                    ram_we_ex_d         = 1'b1;
                    imm_ex_d            = imm_s;
                end
            end
            default: ;
        endcase
    end

    // Execute
    always_comb begin
        op_a   = rs1_value_ex_q;
        rs2_op = rs2_value_ex_q;
`ifdef FORWARDING_EN
        // A matching load in STL blocks the older WB value; its data is not ready yet.
        if (rs1_en_ex_q && (rs1_addr_ex_q != 5'd0)) begin
            if (rd_en_stl_q && (rd_addr_stl_q == rs1_addr_ex_q)) begin
                if (!rd_is_ram_dout_stl_q) op_a = rd_value_stl_q;
            end else if (wb_we && (rd_addr_wb_q == rs1_addr_ex_q)) begin
                op_a = wb_data;
            end
        end
        if (rs2_en_ex_q && (rs2_addr_ex_q != 5'd0)) begin
            if (rd_en_stl_q && (rd_addr_stl_q == rs2_addr_ex_q)) begin
                if (!rd_is_ram_dout_stl_q) rs2_op = rd_value_stl_q;
            end else if (wb_we && (rd_addr_wb_q == rs2_addr_ex_q)) begin
                rs2_op = wb_data;
            end
        end
`endif
        op_b = b_is_immediate_ex_q ? imm_ex_q : rs2_op;
        unique case (alu_op_ex_q)
            AluAdd:  alu_y = op_a + op_b;
            AluSub:  alu_y = op_a - op_b;
            AluSll:  alu_y = op_a << op_b[4:0];
            AluSlt:  alu_y = {31'b0, $signed(op_a) < $signed(op_b)};
            AluSltu: alu_y = {31'b0, op_a < op_b};
            AluXor:  alu_y = op_a ^ op_b;
            AluSrl:  alu_y = op_a >> op_b[4:0];
            AluSra:  alu_y = $signed(op_a) >>> op_b[4:0];
            AluOr:   alu_y = op_a | op_b;
            AluAnd:  alu_y = op_a & op_b;
            default: alu_y = '0;
        endcase
    end

    always_comb begin
        pc_d                 = pc_q + 32'd4;
        rd_en_stl_d          = rd_en_ex_q;
        rd_is_ram_dout_stl_d = rd_is_ram_dout_ex_q;
        ram_we_stl_d         = ram_we_ex_q;
        rd_addr_stl_d        = rd_addr_ex_q;
        rd_value_stl_d       = alu_y;
        store_data_stl_d     = rs2_op;
        rd_en_wb_d           = rd_en_stl_q;
        rd_is_ram_dout_wb_d  = rd_is_ram_dout_stl_q;
        rd_addr_wb_d         = rd_addr_stl_q;
        rd_value_wb_d        = rd_value_stl_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q                 <= RESET_PC;
            rs1_en_ex_q          <= 1'b0;
            rs2_en_ex_q          <= 1'b0;
            rd_en_ex_q           <= 1'b0;
            b_is_immediate_ex_q  <= 1'b0;
            rd_is_ram_dout_ex_q  <= 1'b0;
            ram_we_ex_q          <= 1'b0;
            rd_addr_ex_q         <= '0;
            rs1_addr_ex_q        <= '0;
            rs2_addr_ex_q        <= '0;
            rs1_value_ex_q       <= '0;
            rs2_value_ex_q       <= '0;
            imm_ex_q             <= '0;
            alu_op_ex_q          <= AluAdd;
            rd_en_stl_q          <= 1'b0;
            rd_is_ram_dout_stl_q <= 1'b0;
            ram_we_stl_q         <= 1'b0;
            rd_addr_stl_q        <= '0;
            rd_value_stl_q       <= '0;
            store_data_stl_q     <= '0;
            rd_en_wb_q           <= 1'b0;
            rd_is_ram_dout_wb_q  <= 1'b0;
            rd_addr_wb_q         <= '0;
            rd_value_wb_q        <= '0;
        end else begin
            pc_q                 <= pc_d;
            rs1_en_ex_q          <= rs1_en_ex_d;
            rs2_en_ex_q          <= rs2_en_ex_d;
            rd_en_ex_q           <= rd_en_ex_d;
            b_is_immediate_ex_q  <= b_is_immediate_ex_d;
            rd_is_ram_dout_ex_q  <= rd_is_ram_dout_ex_d;
            ram_we_ex_q          <= ram_we_ex_d;
            rd_addr_ex_q         <= rd_addr_ex_d;
            rs1_addr_ex_q        <= rs1_addr_ex_d;
            rs2_addr_ex_q        <= rs2_addr_ex_d;
            rs1_value_ex_q       <= rs1_value_ex_d;
            rs2_value_ex_q       <= rs2_value_ex_d;
            imm_ex_q             <= imm_ex_d;
            alu_op_ex_q          <= alu_op_ex_d;
            rd_en_stl_q          <= rd_en_stl_d;
            rd_is_ram_dout_stl_q <= rd_is_ram_dout_stl_d;
            ram_we_stl_q         <= ram_we_stl_d;
            rd_addr_stl_q        <= rd_addr_stl_d;
            rd_value_stl_q       <= rd_value_stl_d;
            store_data_stl_q     <= store_data_stl_d;
            rd_en_wb_q           <= rd_en_wb_d;
            rd_is_ram_dout_wb_q  <= rd_is_ram_dout_wb_d;
            rd_addr_wb_q         <= rd_addr_wb_d;
            rd_value_wb_q        <= rd_value_wb_d;
        end
    end

    assign imem_addr = pc_q;
    assign imem_en   = rst_n;
    assign pc_out    = pc_q;
    assign dmem_addr = rd_value_stl_q;
    assign dmem_we   = ram_we_stl_q;
    assign dmem_din  = store_data_stl_q;

    // Operand enables and addresses only steer the bypass network.
    logic unused_ex_fields;
    assign unused_ex_fields = ^{rs1_en_ex_q, rs2_en_ex_q, rs1_addr_ex_q, rs2_addr_ex_q};

endmodule

// File: tb/tb_base_pipeline.sv
module tb_base_pipeline;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr, imem_dout, dmem_addr, dmem_din, dmem_dout, pc_out;
    logic        imem_en, dmem_we;

    base_pipeline #(.RESET_PC(32'h0000_0000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imem_addr (imem_addr),
        .imem_en   (imem_en),
        .imem_dout (imem_dout),
        .dmem_addr (dmem_addr),
        .dmem_we   (dmem_we),
        .dmem_din  (dmem_din),
        .dmem_dout (dmem_dout),
        .pc_out    (pc_out)
    );

    always #5 clk = ~clk;

    logic [31:0] prog [0:255];
    logic [31:0] dmem [0:63];

    // Synchronous instruction memory; output register cleared by reset (opcode 0 = NOP).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) imem_dout <= 32'h0;
        else if (imem_en) imem_dout <= prog[imem_addr[9:2]];
    end

    always @(posedge clk) begin
        if (dmem_we) dmem[dmem_addr[7:2]] <= dmem_din;
        dmem_dout <= dmem[dmem_addr[7:2]];
    end

    int n_tests = 0;
    int n_fail  = 0;

    logic [36:0] wq [$];   // {rd, value} expected register-file writes
    logic [63:0] sq [$];   // {addr, data} expected stores

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_ins(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] s_ins(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [11:0] imm);
        return i_ins(imm, rs1, 3'b000, rd, 7'b0010011);
    endfunction

    task automatic push_w(input logic [4:0] rd, input logic [31:0] v);
        wq.push_back({rd, v});
    endtask

    // Write monitor: sees a committing WB at the negedge, checks the register file after the edge.
    logic [4:0]  mon_addr;
    logic [36:0] mon_exp;
    always @(negedge clk) begin
        if (rst_n && dut.rd_en_wb_q && dut.rd_addr_wb_q != 5'd0) begin
            mon_addr = dut.rd_addr_wb_q;
            @(posedge clk);
            #1;
            if (wq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL wb_unexpected: got write to x%0d, expected no write", mon_addr);
            end else begin
                mon_exp = wq.pop_front();
                check("wb_addr", {27'b0, mon_addr}, {27'b0, mon_exp[36:32]});
                check("wb_data", dut.register_file0.data[mon_addr], mon_exp[31:0]);
            end
        end
    end

    // Store monitor
    logic [63:0] st_exp;
    always @(negedge clk) begin
        if (rst_n && dmem_we) begin
            if (sq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL st_unexpected: got store to %h, expected no store", dmem_addr);
            end else begin
                st_exp = sq.pop_front();
                check("st_addr", dmem_addr, st_exp[63:32]);
                check("st_data", dmem_din, st_exp[31:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 32'h0;
    endtask

    // Hold reset across one edge and release just after it.
    task automatic run_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain(input string name, input int budget);
        int c = 0;
        while ((wq.size() != 0 || sq.size() != 0) && c < budget) begin
            @(posedge clk);
            c++;
        end
        @(posedge clk);
        #2;
        n_tests++;
        if (wq.size() != 0 || sq.size() != 0) begin
            n_fail++;
            $display("FAIL drain_%s: got %0d writes and %0d stores pending, expected 0",
                     name, wq.size(), sq.size());
            wq.delete();
            sq.delete();
        end
    endtask

    logic [31:0] fwd_exp;

    initial begin
        clear_prog();
        for (int i = 0; i < 64; i++) dmem[i] = 32'h0;

        // Reset state
        #2;
        check("rst_pc", pc_out, 32'h0);
        check("rst_imem_en", {31'b0, imem_en}, 32'h0);
        check("rst_rd_en_ex", {31'b0, dut.rd_en_ex_q}, 32'h0);
        check("rst_ram_we_stl", {31'b0, dut.ram_we_stl_q}, 32'h0);
        check("rst_rd_en_wb", {31'b0, dut.rd_en_wb_q}, 32'h0);

        // Preload xi = i through addi
        for (int i = 1; i < 32; i++) begin
            prog[i-1] = addi(5'(i), 5'd0, 12'(i));
            push_w(5'(i), 32'(i));
        end
        run_reset();
        drain("preload", 60);

        // add x1,x16,x17 through each stage
        clear_prog();
        prog[0] = 32'h0118_00b3;
        push_w(5'd1, 32'd33);
        run_reset();
        tick();
        check("pc_after_edge1", pc_out, 32'h4);
        check("imem_en_run", {31'b0, imem_en}, 32'h1);
        tick();
        check("add_rd_en_ex", {31'b0, dut.rd_en_ex_q}, 32'h1);
        check("add_rs1_value_ex", dut.rs1_value_ex_q, 32'd16);
        check("add_rs2_value_ex", dut.rs2_value_ex_q, 32'd17);
        tick();
        check("add_rd_value_stl", dut.rd_value_stl_q, 32'd33);
        tick();
        check("add_rd_value_wb", dut.rd_value_wb_q, 32'd33);
        check("add_x1_not_yet", dut.register_file0.data[1], 32'd1);
        tick();
        check("add_x1_edge5", dut.register_file0.data[1], 32'd33);
        drain("add", 10);

        // R-type stream
        clear_prog();
        prog[0] = r_ins(7'h00, 5'd17, 5'd16, 3'b000, 5'd1);  push_w(5'd1,  32'd33);
        prog[1] = r_ins(7'h20, 5'd18, 5'd17, 3'b000, 5'd2);  push_w(5'd2,  32'hFFFF_FFFF);
        prog[2] = r_ins(7'h00, 5'd19, 5'd18, 3'b001, 5'd3);  push_w(5'd3,  32'd18 << 19);
        prog[3] = r_ins(7'h00, 5'd20, 5'd19, 3'b010, 5'd4);  push_w(5'd4,  32'd1);
        prog[4] = r_ins(7'h00, 5'd21, 5'd20, 3'b011, 5'd5);  push_w(5'd5,  32'd1);
        prog[5] = r_ins(7'h00, 5'd22, 5'd21, 3'b100, 5'd6);  push_w(5'd6,  32'd3);
        prog[6] = r_ins(7'h00, 5'd23, 5'd22, 3'b101, 5'd7);  push_w(5'd7,  32'd0);
        prog[7] = r_ins(7'h20, 5'd24, 5'd23, 3'b101, 5'd8);  push_w(5'd8,  32'd0);
        prog[8] = r_ins(7'h00, 5'd25, 5'd24, 3'b110, 5'd9);  push_w(5'd9,  32'd25);
        prog[9] = r_ins(7'h00, 5'd26, 5'd25, 3'b111, 5'd10); push_w(5'd10, 32'd24);
        run_reset();
        repeat (4) tick();
        check("stream_wb_add", dut.rd_value_wb_q, 32'd33);
        check("stream_stl_sub", dut.rd_value_stl_q, 32'hFFFF_FFFF);
        check("stream_ex_sll_a", dut.rs1_value_ex_q, 32'd18);
        check("stream_ex_sll_b", dut.rs2_value_ex_q, 32'd19);
        check("stream_ex_sll_rd", {27'b0, dut.rd_addr_ex_q}, 32'd3);
        drain("rtype", 30);

        // OP-IMM, including signed compares and shifts on a negative operand
        clear_prog();
        prog[0] = addi(5'd5, 5'd0, 12'hFFF);                  push_w(5'd5,  32'hFFFF_FFFF);
        prog[1] = r_ins(7'h00, 5'd16, 5'd2, 3'b010, 5'd12);   push_w(5'd12, 32'd1);
        prog[2] = r_ins(7'h00, 5'd16, 5'd2, 3'b011, 5'd13);   push_w(5'd13, 32'd0);
        prog[3] = i_ins(12'h404, 5'd2, 3'b101, 5'd14, 7'b0010011); push_w(5'd14, 32'hFFFF_FFFF);
        prog[4] = i_ins(12'h01C, 5'd2, 3'b101, 5'd15, 7'b0010011); push_w(5'd15, 32'hF);
        run_reset();
        repeat (2) tick();
        check("addi_b_is_imm_ex", {31'b0, dut.b_is_immediate_ex_q}, 32'h1);
        check("addi_rs2_en_ex", {31'b0, dut.rs2_en_ex_q}, 32'h0);
        check("addi_imm_ex", dut.imm_ex_q, 32'hFFFF_FFFF);
        drain("opimm", 20);

        // sw / lw / write to x0
        clear_prog();
        prog[0] = addi(5'd3, 5'd0, 12'd7);                    push_w(5'd3, 32'd7);
        prog[4] = s_ins(12'd8, 5'd3, 5'd0);                   sq.push_back({32'd8, 32'd7});
        prog[5] = i_ins(12'd8, 5'd0, 3'b010, 5'd4, 7'b0000011); push_w(5'd4, 32'd7);
        prog[6] = r_ins(7'h00, 5'd1, 5'd1, 3'b000, 5'd0);
        run_reset();
        repeat (7) tick();
        check("sw_dmem_we", {31'b0, dmem_we}, 32'h1);
        check("sw_dmem_addr", dmem_addr, 32'd8);
        check("sw_dmem_din", dmem_din, 32'd7);
        tick();
        check("x0_rd_en_ex", {31'b0, dut.rd_en_ex_q}, 32'h0);
        tick();
        check("lw_rd_is_ram_dout_wb", {31'b0, dut.rd_is_ram_dout_wb_q}, 32'h1);
        drain("mem", 20);
        check("x0_stays_zero", dut.register_file0.data[0], 32'h0);

        // Reset while addi x27,x0,99 sits in WB
        clear_prog();
        prog[0] = addi(5'd27, 5'd0, 12'd99);
        run_reset();
        repeat (4) tick();
        check("midrst_pre_rd_en_wb", {31'b0, dut.rd_en_wb_q}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("midrst_pc", pc_out, 32'h0);
        check("midrst_rd_en_ex", {31'b0, dut.rd_en_ex_q}, 32'h0);
        check("midrst_ram_we_ex", {31'b0, dut.ram_we_ex_q}, 32'h0);
        check("midrst_rd_en_stl", {31'b0, dut.rd_en_stl_q}, 32'h0);
        check("midrst_rd_en_wb", {31'b0, dut.rd_en_wb_q}, 32'h0);
        clear_prog();
        tick();
        check("midrst_no_write", dut.register_file0.data[27], 32'd27);
        rst_n = 1'b1;
        tick();
        check("midrst_no_write_after", dut.register_file0.data[27], 32'd27);
        check("midrst_pc_restart", pc_out, 32'h4);
        drain("midrst", 10);

        // Back-to-back dependence (STL bypass) and distance-2 dependence (WB bypass)
`ifdef FORWARDING_EN
        fwd_exp = 32'd10;
`else
        fwd_exp = 32'd66;
`endif
        clear_prog();
        prog[0] = addi(5'd1, 5'd0, 12'd5);                   push_w(5'd1, 32'd5);
        prog[1] = r_ins(7'h00, 5'd1, 5'd1, 3'b000, 5'd2);    push_w(5'd2, fwd_exp);
        prog[2] = r_ins(7'h00, 5'd1, 5'd1, 3'b000, 5'd3);    push_w(5'd3, fwd_exp);
        run_reset();
        drain("fwd", 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
